// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types and helpers for the FPU Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Widest operand any multiplier instance may be built with.
    localparam int BOOTH_MAX_W = 64;

    typedef enum logic [1:0] {
        Booth_Idle   = 2'd0,
        Mult_Compute = 2'd1,
        Mult_Done    = 2'd2
    } BoothState;

    // The caller supplies value zero-padded above the operand width. Every bit
    // at or above 'width' becomes copies of the operand MSB when sgn is set,
    // and zero otherwise.
    function automatic logic [BOOTH_MAX_W:0] booth_ext(
        input logic [BOOTH_MAX_W-1:0] value,
        input int                     width,
        input logic                   sgn
    );
        logic [BOOTH_MAX_W-1:0] msb_down;
        logic [BOOTH_MAX_W:0]   upper;
        logic                   fill;
        msb_down = value >> (width - 1);
        fill     = sgn & msb_down[0];
        upper    = {(BOOTH_MAX_W+1){1'b1}} << width;
        return ({1'b0, value} & ~upper) | (fill ? upper : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth iteration: add/subtract M, then arithmetic
//               right shift of {A,Q,Q_1}. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step #(
    parameter int N = 25
) (
    input  logic [N:0]   a_i,
    input  logic [N-1:0] q_i,
    input  logic         q1_i,
    input  logic [N-1:0] m_i,
    output logic [N:0]   a_o,
    output logic [N-1:0] q_o,
    output logic         q1_o
);

    logic [N:0] w_m_sx;
    logic [N:0] w_sum;

    // A has one guard bit, so subtracting the most-negative M cannot wrap.
    assign w_m_sx = {m_i[N-1], m_i};

    always_comb begin
        w_sum = a_i;
        case ({q_i[0], q1_i})
            2'b01:   w_sum = a_i + w_m_sx;
            2'b10:   w_sum = a_i - w_m_sx;
            default: w_sum = a_i;
        endcase
    end

    assign a_o  = {w_sum[N], w_sum[N:1]};
    assign q_o  = {w_sum[0], q_i[N-1:1]};
    assign q1_o = q_i[0];

endmodule
`default_nettype wire

// File: rtl/booth_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_param
// Description : Parametrised radix-2 Booth sequential multiplier with
//               BREQ/BACK handshake and per-operation signed/unsigned mode.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_param
    import fpu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RSTK,
    input  logic                 BREQ,
    input  logic                 SGN,
    input  logic [WIDTH-1:0]     m1,
    input  logic [WIDTH-1:0]     m2,
    output logic                 BUSY,
    output logic                 BACK,
    output logic [2*WIDTH-1:0]   res
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    generate
        if (WIDTH < 4 || WIDTH > BOOTH_MAX_W) begin : g_bad_width
            $error("booth_mult_param: WIDTH out of supported range");
        end
    endgenerate

    BoothState       state_q, state_d;
    logic [N:0]      a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [N-1:0]    m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   res_q, res_d;

    logic [N-1:0]    w_m1_ext;
    logic [N-1:0]    w_m2_ext;
    logic [N:0]      w_a_nxt;
    logic [N-1:0]    w_q_nxt;
    logic            w_q1_nxt;

    assign w_m1_ext = N'(booth_ext(BOOTH_MAX_W'(m1), WIDTH, SGN));
    assign w_m2_ext = N'(booth_ext(BOOTH_MAX_W'(m2), WIDTH, SGN));

    booth_step #(
        .N (N)
    ) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (w_a_nxt),
        .q_o  (w_q_nxt),
        .q1_o (w_q1_nxt)
    );

    always_ff @(posedge CLK) begin
        if (RSTK) begin
            state_q <= Booth_Idle;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            Booth_Idle: begin
                if (BREQ) begin
                    a_d     = '0;
                    m_d     = w_m1_ext;
                    q_d     = w_m2_ext;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = Mult_Compute;
                end
            end
            Mult_Compute: begin
                a_d   = w_a_nxt;
                q_d   = w_q_nxt;
                q1_d  = w_q1_nxt;
                cnt_d = cnt_q + 1'b1;
                // Product is taken from the post-shift values of the last step.
                if (cnt_q == LAST_CNT) begin
                    state_d = Mult_Done;
                    res_d   = PW'({w_a_nxt, w_q_nxt});
                end
            end
            Mult_Done: begin
                state_d = Booth_Idle;
            end
            default: begin
                state_d = Booth_Idle;
            end
        endcase
    end

    assign BUSY = (state_q != Booth_Idle);
    assign BACK = (state_q == Mult_Done);
    assign res  = res_q;

endmodule
`default_nettype wire
